// File: rtl/uart_tx_sched_if.sv
// Channel and transmitter handshake bundle for the two-channel UART transmit scheduler.
// The master side is the environment; the slave side is the scheduler.
interface uart_tx_sched_if;
  logic       en;
  logic       c0_valid;
  logic [7:0] c0_dat;
  logic       c0_ready;
  logic       c1_valid;
  logic [7:0] c1_dat;
  logic       c1_ready;
  logic       tx_send;
  logic [7:0] tx_dat;
  logic       tx_busy;
  logic       tx_done;
  logic [1:0] gnt;
  logic [1:0] pend;

  modport master (
    output en, c0_valid, c0_dat, c1_valid, c1_dat, tx_busy, tx_done,
    input  c0_ready, c1_ready, tx_send, tx_dat, gnt, pend
  );

  modport slave (
    input  en, c0_valid, c0_dat, c1_valid, c1_dat, tx_busy, tx_done,
    output c0_ready, c1_ready, tx_send, tx_dat, gnt, pend
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-channel byte scheduler feeding one UART transmitter: per-channel FIFOs,
// round-robin arbitration and an IDLE/ISSUE/WAIT frame sequencer.
module uart_tx_sched #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          clk,
  input logic          rst,
  uart_tx_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      valid, push, pop, ready, pend;
  logic [1:0][7:0] dat, head;
  logic [7:0]      tx_dat_reg;
  logic [1:0]      gnt_reg;
  logic            last_gnt_reg;
  logic            sel;

  assign valid  = {bus.c1_valid, bus.c0_valid};
  assign dat[0] = bus.c0_dat;
  assign dat[1] = bus.c1_dat;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [DEPTH];
      logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
      logic [AW:0]   count_reg;

      assign ready[gi] = (count_reg != (AW+1)'(DEPTH));
      assign pend[gi]  = (count_reg != '0);
      assign push[gi]  = valid[gi] & ready[gi];
      assign head[gi]  = mem[rd_ptr_reg];

      // Storage carries no reset; the pointers and count alone define contents.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wr_ptr_reg] <= dat[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Round-robin: a lone pending channel wins, otherwise the one not served last.
  always_comb begin
    state_next = state_reg;
    pop        = '0;
    sel        = (pend == 2'b11) ? ~last_gnt_reg : pend[1];
    case (state_reg)
      IDLE: begin
        if (bus.en && !bus.tx_busy && (pend != 2'b00)) begin
          state_next = ISSUE;
          pop[sel]   = 1'b1;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (bus.tx_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      tx_dat_reg   <= 8'h00;
      gnt_reg      <= 2'b00;
      last_gnt_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (pop != 2'b00) begin
        tx_dat_reg <= head[sel];
        gnt_reg    <= sel ? 2'b10 : 2'b01;
      end else if (state_reg == WAIT && bus.tx_done) begin
        last_gnt_reg <= gnt_reg[1];
        gnt_reg      <= 2'b00;
      end
    end
  end

  assign bus.c0_ready = ready[0];
  assign bus.c1_ready = ready[1];
  assign bus.pend     = pend;
  assign bus.tx_send  = (state_reg == ISSUE);
  assign bus.tx_dat   = tx_dat_reg;
  assign bus.gnt      = gnt_reg;
endmodule
